// File: rtl/gpio_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bus_arbiter_pkg
// Description : Shared definitions for the two-master GPIO bus arbiter:
//               FSM state encoding, master indices and GPIO register offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_bus_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Master indices (also the bit positions in the req/gnt vectors)
    localparam logic c_M0 = 1'b0;
    localparam logic c_M1 = 1'b1;

    // GPIO register offsets, shared with benches and software headers
    localparam logic [3:0] c_REG_CTRL = 4'h0;
    localparam logic [3:0] c_REG_DATA = 4'h4;

endpackage : gpio_bus_arbiter_pkg
`default_nettype wire

// File: rtl/gpio_bus_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester picker. A lone requester always wins; on a tie
//               the pointer picks the winner when round-robin is enabled,
//               otherwise requester 0 wins. Output is one-hot (or zero).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    // Pick one winner from the request pair
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11: begin
                if ((RR_EN != 0) && (i_ptr == c_M1)) begin
                    o_gnt = 2'b10;
                end else begin
                    o_gnt = 2'b01;
                end
            end
            default: o_gnt = 2'b00;
        endcase
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/gpio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bus_arbiter
// Description : Shares the single GPIO register port between the CPU core
//               (m0) and the debug module (m1). One transaction at a time:
//               grant in IDLE, drive the GPIO port in ACCESS, return the
//               registered response in RESP.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bus_arbiter
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // master 0 (CPU core)
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    // master 1 (debug module)
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    // GPIO register port
    output logic              o_s_wr_en,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [DATA_W-1:0] o_s_wdata,
    input  logic [DATA_W-1:0] i_s_rdata
);

    state_t              r_state;
    logic                r_ptr;
    logic                r_owner;
    logic                r_s_wr_en;
    logic [ADDR_W-1:0]   r_s_addr;
    logic [DATA_W-1:0]   r_s_wdata;
    logic                r_m0_rvalid;
    logic                r_m1_rvalid;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic [1:0]          w_req;
    logic [1:0]          w_arb_gnt;
    logic [1:0]          w_gnt;
    logic                w_win;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    assign w_req = {i_m1_req, i_m0_req};

    rr_arbiter2 #(
        .RR_EN (RR_EN)
    ) u_rr_arbiter2 (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt)
    );

    // Grants only exist in IDLE and never while reset is held
    assign w_gnt       = (rst_n && (r_state == IDLE)) ? w_arb_gnt : 2'b00;
    assign w_win       = w_arb_gnt[1];
    assign w_sel_we    = (w_win == c_M1) ? i_m1_we    : i_m0_we;
    assign w_sel_addr  = (w_win == c_M1) ? i_m1_addr  : i_m0_addr;
    assign w_sel_wdata = (w_win == c_M1) ? i_m1_wdata : i_m0_wdata;

    assign o_m0_gnt    = w_gnt[0];
    assign o_m1_gnt    = w_gnt[1];
    assign o_m0_rvalid = r_m0_rvalid;
    assign o_m1_rvalid = r_m1_rvalid;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;
    assign o_s_wr_en   = r_s_wr_en;
    assign o_s_addr    = r_s_addr;
    assign o_s_wdata   = r_s_wdata;

    // Transaction FSM: latch the winner, drive the GPIO port, return response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= c_M0;
            r_owner     <= c_M0;
            r_s_wr_en   <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_m0_rvalid <= 1'b0;
                    r_m1_rvalid <= 1'b0;
                    if (w_gnt != 2'b00) begin
                        r_owner   <= w_win;
                        r_s_wr_en <= w_sel_we;
                        r_s_addr  <= w_sel_addr;
                        r_s_wdata <= w_sel_wdata;
                        // The loser gets preference on the next tie
                        if (RR_EN != 0) begin
                            r_ptr <= ~w_win;
                        end
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write strobe lasts exactly this one cycle
                    r_s_wr_en <= 1'b0;
                    if (r_owner == c_M1) begin
                        r_m1_rvalid <= 1'b1;
                        r_m1_rdata  <= r_s_wr_en ? '0 : i_s_rdata;
                    end else begin
                        r_m0_rvalid <= 1'b1;
                        r_m0_rdata  <= r_s_wr_en ? '0 : i_s_rdata;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_m0_rvalid <= 1'b0;
                    r_m1_rvalid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_s_wr_en   <= 1'b0;
                    r_m0_rvalid <= 1'b0;
                    r_m1_rvalid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule : gpio_bus_arbiter
`default_nettype wire
